// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the RV32I pipeline boundary registers: stage state encoding,
// the NOP bubble word, and per-boundary payload widths derived from the stage structs.
package pipe_stage_reg_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;

  parameter word_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } if_id_t;

  typedef struct packed {
    word_t      pc;
    word_t      rs1_val;
    word_t      rs2_val;
    word_t      imm;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic [5:0] ctrl;
  } id_ex_t;

  typedef struct packed {
    word_t      alu_res;
    word_t      rs2_val;
    logic [4:0] rd;
    logic [5:0] ctrl;
  } ex_mem_t;

  typedef struct packed {
    word_t      wb_val;
    logic [4:0] rd;
    logic       reg_we;
  } mem_wb_t;

  localparam int IF_ID_WIDTH  = $bits(if_id_t);
  localparam int ID_EX_WIDTH  = $bits(id_ex_t);
  localparam int EX_MEM_WIDTH = $bits(ex_mem_t);
  localparam int MEM_WB_WIDTH = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: 1-cycle latency, valid/ready with optional 2-entry skid
// (registered o_ready) or single entry (combinational o_ready); flush injects a bubble.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             emit;

  assign o_valid     = (state_q != PS_EMPTY);
  assign o_data      = o_valid ? main_q : BUBBLE;
  assign o_stall_cnt = cnt_q;
  assign accept      = i_valid & o_ready;
  assign emit        = o_valid & i_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;
      // Ready is a flop so the upstream stall path never sees i_ready combinationally.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != PS_FULL);
        end
      end
      assign o_ready = ready_q;
    end else begin : g_noskid
      assign o_ready = ~o_valid | i_ready;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          main_d  = i_data;
          state_d = PS_ONE;
        end
      end
      PS_ONE: begin
        if (accept && emit) begin
          main_d = i_data;
        end else if (accept) begin
          skid_d  = i_data;
          state_d = PS_FULL;
        end else if (emit) begin
          state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = PS_ONE;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    // A flush drops any same-cycle accept; a same-cycle emit has already been taken downstream.
    if (i_flush) begin
      state_d = PS_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= PS_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (o_valid && !i_ready && !(&cnt_q)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid instance (small counter, non-zero bubble)
// and a wide single-entry instance, both checked against a queue-occupancy model.
module tb_pipe_stage_reg;

  localparam int               AW     = 64;
  localparam logic [AW-1:0]    A_BUB  = 64'hB0B0_0000_0000_0013;
  localparam int               A_CMAX = 15;
  localparam int               BW     = 250;
  localparam logic [BW-1:0]    B_BUB  = '0;
  localparam int               B_CMAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_valid, a_rdy, a_flush, a_o_ready, a_o_valid;
  logic [AW-1:0] a_data, a_o_data;
  logic [3:0]    a_cnt;
  logic          b_valid, b_rdy, b_flush, b_o_ready, b_o_valid;
  logic [BW-1:0] b_data, b_o_data;
  logic [15:0]   b_cnt;

  pipe_stage_reg #(.WIDTH(AW), .SKID(1), .BUBBLE(A_BUB), .CNT_W(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_o_ready), .i_data(a_data),
    .o_valid(a_o_valid), .i_ready(a_rdy), .o_data(a_o_data), .i_flush(a_flush),
    .o_stall_cnt(a_cnt)
  );

  pipe_stage_reg #(.WIDTH(BW), .SKID(0), .BUBBLE(B_BUB), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_o_ready), .i_data(b_data),
    .o_valid(b_o_valid), .i_ready(b_rdy), .o_data(b_o_data), .i_flush(b_flush),
    .o_stall_cnt(b_cnt)
  );

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;
  int   a_exp_cnt = 0;
  int   b_exp_cnt = 0;
  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor A: items held by the stage form an in-order queue; skid stage holds at most two.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", 256'(a_o_valid), 256'(qa.size() > 0));
      chk("a_ready", 256'(a_o_ready), 256'(qa.size() < 2));
      chk("a_cnt", 256'(a_cnt), 256'(a_exp_cnt));
      if (!a_o_valid) chk("a_bubble", 256'(a_o_data), 256'(A_BUB));
      if (!rst_n) begin
        a_exp_cnt = 0;
      end else begin
        if (qa.size() > 0 && !a_rdy && a_exp_cnt < A_CMAX) a_exp_cnt++;
        if (a_o_valid && a_rdy) begin
          if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_extra act=%0h exp=none", a_o_data);
          end else begin
            logic [AW-1:0] e;
            e = qa.pop_front();
            chk("a_data", 256'(a_o_data), 256'(e));
          end
        end
      end
    end
  end

  // Monitor B: single entry, ready whenever empty or downstream takes the item.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("b_valid", 256'(b_o_valid), 256'(qb.size() > 0));
      chk("b_ready", 256'(b_o_ready), 256'(qb.size() == 0 || b_rdy));
      chk("b_cnt", 256'(b_cnt), 256'(b_exp_cnt));
      if (!b_o_valid) chk("b_bubble", 256'(b_o_data), 256'(B_BUB));
      if (!rst_n) begin
        b_exp_cnt = 0;
      end else begin
        if (qb.size() > 0 && !b_rdy && b_exp_cnt < B_CMAX) b_exp_cnt++;
        if (b_o_valid && b_rdy) begin
          if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_extra act=%0h exp=none", b_o_data);
          end else begin
            logic [BW-1:0] e;
            e = qb.pop_front();
            chk("b_data", 256'(b_o_data), 256'(e));
          end
        end
      end
    end
  end

  // Stimulus side: record accepted payloads after the monitors have taken this cycle's emit.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n || a_flush) qa.delete();
    else if (a_valid && a_o_ready) qa.push_back(a_data);
    if (!rst_n || b_flush) qb.delete();
    else if (b_valid && b_o_ready) qb.push_back(b_data);
  end

  task automatic a_put(input logic [AW-1:0] d);
    logic ok;
    ok = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("a_put_accept", 256'(ok), 256'(1));
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic b_put(input logic [BW-1:0] d);
    logic ok;
    ok = 1'b0;
    b_valid = 1'b1;
    b_data  = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b_put_accept", 256'(ok), 256'(1));
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] r;
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 64'hA5; a_rdy = 1'b1; a_flush = 1'b0;
    b_valid = 1'b1; b_data = 250'hA5; b_rdy = 1'b1; b_flush = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("rst_a_valid", 256'(a_o_valid), 256'(0));
    chk("rst_a_data", 256'(a_o_data), 256'(A_BUB));
    chk("rst_a_cnt", 256'(a_cnt), 256'(0));
    chk("rst_a_ready", 256'(a_o_ready), 256'(1));
    chk("rst_b_data", 256'(b_o_data), 256'(B_BUB));

    for (int i = 1; i <= 8; i++) a_put(AW'(i));
    repeat (3) @(posedge clk);
    #1;

    fork
      begin a_put(64'd1); a_put(64'd2); a_put(64'd3); end
      begin @(posedge clk); #1 a_rdy = 1'b0; repeat (4) @(posedge clk); #1 a_rdy = 1'b1; end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_cnt", 256'(a_cnt), 256'(4));

    a_rdy = 1'b0;
    a_valid = 1'b1;
    a_data = 64'd10;
    @(posedge clk);
    #1 a_data = 64'd11;
    @(posedge clk);
    #1;
    chk("full_ready_low", 256'(a_o_ready), 256'(0));
    a_data = 64'd9;
    a_flush = 1'b1;
    @(posedge clk);
    #1;
    a_flush = 1'b0;
    a_valid = 1'b0;
    chk("flush_valid", 256'(a_o_valid), 256'(0));
    chk("flush_data", 256'(a_o_data), 256'(A_BUB));
    chk("flush_ready", 256'(a_o_ready), 256'(1));
    a_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    a_valid = 1'b1;
    a_data = 64'd77;
    a_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt", 256'(a_cnt), 256'(15));
    a_valid = 1'b0;
    a_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    fork
      begin for (int i = 1; i <= 6; i++) b_put(BW'(i) << 200 | BW'(i)); end
      begin
        repeat (3) @(posedge clk);
        #1 b_rdy = 1'b0;
        #1 chk("b_ready_comb_lo", 256'(b_o_ready), 256'(qb.size() == 0));
        @(posedge clk);
        #1 b_rdy = 1'b1;
        #1 chk("b_ready_comb_hi", 256'(b_o_ready), 256'(1));
      end
    join
    repeat (3) @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      rst_n   = (c != 200);
      a_valid = ($urandom % 4) != 0;
      a_data  = {$urandom, $urandom};
      a_rdy   = ($urandom % 3) != 0;
      a_flush = ($urandom % 25) == 0;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_valid = ($urandom % 4) != 0;
      b_data  = r[BW-1:0];
      b_rdy   = ($urandom % 3) != 0;
      b_flush = ($urandom % 25) == 0;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    a_valid = 1'b0; a_flush = 1'b0; a_rdy = 1'b1;
    b_valid = 1'b0; b_flush = 1'b0; b_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 256'(qa.size() + qb.size()), 256'(0));
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register used at each of the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries of the pipelined RV32I core. It replaces the fixed-width struct registers with one block that adds:
- valid/ready flow control
- an optional 2-entry skid buffer, so `o_ready` is registered
- flush with bubble injection
- a saturating back-pressure counter for performance debug

The payload is an opaque packed vector. Stage structs are cast in and out of it.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits. Use `IF_ID_WIDTH`, `ID_EX_WIDTH`, `EX_MEM_WIDTH` or `MEM_WB_WIDTH`.
- `SKID`, 1: 1 = 2-entry skid buffer with registered `o_ready`; 0 = single register with combinational `o_ready`.
- `BUBBLE`, `'0`: payload value presented on `o_data` while empty or after a flush.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `i_clk`  in  1: clock. Everything is on the rising edge.
- `i_rst_n`  in  1: synchronous, active-low reset.
- `i_valid`  in  1: upstream has a payload.
- `o_ready`  out  1: stage accepts a payload this cycle.
- `i_data`  in  WIDTH: upstream payload.
- `o_valid`  out  1: `o_data` holds a live instruction.
- `i_ready`  in  1: downstream consumes this cycle. Tie to `~stall` for a classic stall.
- `o_data`  out  WIDTH: payload toward the next stage.
- `i_flush`  in  1: kill all held entries (branch taken or jump).
- `o_stall_cnt`  out  CNT_W: saturating count of cycles with `o_valid & ~i_ready`.

## Operation
- **Handshakes.** Accept when `i_valid & o_ready`. Emit when `o_valid & i_ready`.
- **SKID=1 state machine**, states EMPTY, ONE, FULL:
  - EMPTY: on accept, load main → ONE.
  - ONE, accept and emit: load main with `i_data`; stay in ONE.
  - ONE, accept without emit: load skid with `i_data` → FULL.
  - ONE, emit without accept → EMPTY.
  - FULL: `o_ready`=0. On emit: main ← skid → ONE.
- **SKID=0:** `o_ready = ~o_valid | i_ready`. The register loads on accept. On emit without accept it goes empty.
- **Outputs:** `o_data` = main register when `o_valid`=1, else `BUBBLE`.
- **Flush:**
  - Next state is EMPTY, and main and skid are loaded with `BUBBLE`.
  - A same-cycle accept is discarded, and the upstream handshake still counts as consumed.
  - A same-cycle emit still completes: the downstream register captures the current `o_data`.
  - Flush has priority over every transition.
- **Counter:**
  - Increments when `o_valid & ~i_ready`.
  - Saturates at all-ones. It does not wrap.
  - It is not cleared by flush. Only reset clears it.
- **Reset** (sync, `i_rst_n`=0 at the edge) takes priority over flush. It applies:
  - state = EMPTY, `o_valid`=0, `o_data`=`BUBBLE`
  - `o_ready`=1 (SKID=1: registered, so valid from the first cycle after reset)
  - `o_stall_cnt`=0, skid = `BUBBLE`

## Timing
- **Latency:** 1 cycle from accept to `o_valid`, with no back-pressure.
- **Throughput:** 1 item per cycle in steady state, both modes.
- **SKID=1:**
  - `o_ready` is a flop output (= state != FULL).
  - `o_ready` does not depend on `i_ready` in the same cycle.
  - At most one extra item is accepted after downstream stalls.
- **SKID=0:** `o_ready` depends combinationally on `i_ready`, so the stall path is combinational through the stage.
- **Ordering:** data order is preserved. The skid entry is never emitted ahead of main.
- **Flush:** `o_valid`=0 in the cycle after `i_flush`. `o_ready`=1 in that cycle.
- **Reset mid-transfer:** held data is lost. No partial output.

## Structure
- **`package_param` additions:**
  - `typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t`
  - `parameter word_t NOP_INST = 32'h0000_0013`, for callers that want a NOP bubble
  - the existing `*_WIDTH` macros, updated to equal `$bits()` of each stage struct
- **Sub-module:** none. Main and skid registers plus the FSM sit in one module.
- **Pipeline use:** one instance per stage boundary.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 2 cycles with `i_valid`=1 and `i_data`=0xA5 → `o_valid`=0, `o_data`=`BUBBLE`, `o_stall_cnt`=0. The cycle after release, `o_ready`=1.
- **Streaming, SKID=1:** send payloads 1..8 back to back with `i_ready`=1 → outputs 1..8 on consecutive cycles, 1 cycle late, with no gaps.
- **Back-pressure:** stream 1,2,3 and drop `i_ready` for 4 cycles → `o_ready` falls after 2 accepts (FULL holding 1 and 2). `o_stall_cnt`=4. On release, outputs are 1,2,3 in order.
- **Flush while FULL, with `i_valid`=1 carrying 9:**
  - Next cycle: `o_valid`=0, `o_data`=`BUBBLE`, `o_ready`=1.
  - Payload 9 never appears at the output.
- **SKID=0, `WIDTH`=250, `BUBBLE`=0:** stall one cycle mid-stream → `o_ready` tracks `i_ready` in the same cycle and no item is duplicated or lost.
- **Counter saturation:** with `CNT_W`=4, stall for 20 cycles → the count reads 15 and holds.
